// File: rtl/encoder_controller.sv
// Sequencing FSM for the slice-serial encoder: runs ROUNDS rounds of a 64-slice
// read pass followed by a 64-slice process/write-back pass, driven by the slice counter.
module encoder_controller #(
    parameter int ROUNDS = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    input  logic       co,
    output logic       counter_rst,
    output logic       inc_counter,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       step_en,
    output logic [4:0] round,
    output logic       ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READ,
        PROC,
        ROUND_END,
        DONE
    } state_t;

    state_t state, state_nxt;
    logic   last_round;

    assign last_round = (round == 5'(ROUNDS - 1));

    // round is cleared on INIT rather than on entry to IDLE, so it still reads
    // ROUNDS-1 in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            round <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                round <= '0;
            else if (state == ROUND_END && !last_round)
                round <= round + 5'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_rst = 1'b0;
        inc_counter = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        step_en     = 1'b0;
        ready       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (start)
                    state_nxt = INIT;
            end
            INIT: begin
                counter_rst = 1'b1;
                state_nxt   = READ;
            end
            READ: begin
                if (!stall) begin
                    mem_rd      = 1'b1;
                    inc_counter = 1'b1;
                    if (co)
                        state_nxt = PROC;
                end
            end
            PROC: begin
                if (!stall) begin
                    mem_wr      = 1'b1;
                    step_en     = 1'b1;
                    inc_counter = 1'b1;
                    if (co)
                        state_nxt = ROUND_END;
                end
            end
            ROUND_END: begin
                // Count has already wrapped to 0; the clear is belt-and-braces.
                counter_rst = 1'b1;
                state_nxt   = last_round ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
